// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control sequencer for Datapath_P2
//
// Purpose:
//   Steps the datapath through instruction fetch (T0-T2) and then executes
//   ld, st, addi, br, jr, nop and halt, advancing one control step per rising
//   edge of Clock. Control strobes are decoded combinationally from the
//   current step and IR[31:27]. The datapath captures them on the edge that
//   ends the step.
//
// Optional feature (macro CU_STOP_EN):
//   Adds input Stop. If Stop=1 on the final step of an instruction, the FSM
//   goes to S_HALT instead of T0. Stop has no effect on any other step.
//
// Ports:
//   Clock                      in   system clock, rising edge
//   Clear                      in   synchronous active-high reset to S_RST
//   IR[31:0]                   in   instruction register (only [31:27] decoded)
//   CON                        in   branch condition flip-flop
//   Stop                       in   (CU_STOP_EN only) halt at end of instruction
//   PCout,Zhighout,Zlowout,
//   MDRout,MARin,Zin,PCin,
//   MDRin,IRin,Yin             out  bus driver / register load strobes
//   IncPC,Read,Write,Gra,Grb,
//   Grc,Rin,Rout,BAout,Cout,
//   CONIn,ADD                  out  datapath control / ALU select
//   Run                        out  1 in T0..T7, 0 in S_RST and S_HALT

module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON,
`ifdef CU_STOP_EN
  input  logic        Stop,
`endif
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONIn,
  output logic        ADD,
  output logic        Run
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    T7     = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t state;
  state_t state_nominal;
  state_t state_next;

  logic [4:0] opcode;
  logic       is_ld, is_st, is_addi, is_br, is_jr, is_halt;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Opcode classes. nop and every undefined opcode fall through as "none of
  // these", which the sequencing below treats as a one-step no-op.
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_addi = (opcode == OP_ADDI);
  assign is_br   = (opcode == OP_BR);
  assign is_jr   = (opcode == OP_JR);
  assign is_halt = (opcode == OP_HALT);

  // Nominal step sequencing, before the optional Stop override.
  always_comb begin
    state_nominal = S_RST;
    case (state)
      S_RST:  state_nominal = T0;
      T0:     state_nominal = T1;
      T1:     state_nominal = T2;
      T2:     state_nominal = T3;
      T3: begin
        if (is_ld || is_st || is_addi || is_br)
          state_nominal = T4;
        else if (is_halt)
          state_nominal = S_HALT;
        else
          state_nominal = T0;        // jr, nop, undefined
      end
      T4:     state_nominal = T5;
      T5:     state_nominal = is_addi ? T0 : T6;
      T6:     state_nominal = (is_ld || is_st) ? T7 : T0;
      T7:     state_nominal = T0;
      S_HALT: state_nominal = S_HALT;
      default: state_nominal = S_RST;  // unreachable encodings recover via reset state
    endcase
  end

  // Stop only matters on an instruction's last step, which is any transition
  // into T0 except the S_RST -> T0 startup.
  always_comb begin
    state_next = state_nominal;
`ifdef CU_STOP_EN
    if (Stop && (state_nominal == T0) && (state != S_RST))
      state_next = S_HALT;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Clear)
      state <= S_RST;
    else
      state <= state_next;
  end

  // Moore control decode. Every strobe defaults low. Zhighout and Grc are
  // never used by this instruction set and stay low.
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    Cout     = 1'b0;
    CONIn    = 1'b0;
    ADD      = 1'b0;
    Run      = 1'b0;

    case (state)
      T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Run = 1'b1;
        if (is_ld || is_st) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (is_addi) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_br) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          CONIn = 1'b1;
        end else if (is_jr) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          PCin = 1'b1;
        end
        // halt, nop and undefined opcodes: no strobes in T3
      end
      T4: begin
        Run = 1'b1;
        if (is_br) begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end else if (is_ld || is_st || is_addi) begin
          Cout = 1'b1;
          ADD  = 1'b1;
          Zin  = 1'b1;
        end
      end
      T5: begin
        Run = 1'b1;
        if (is_br) begin
          Cout = 1'b1;
          ADD  = 1'b1;
          Zin  = 1'b1;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1;
          MARin   = 1'b1;
        end else if (is_addi) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      T6: begin
        Run = 1'b1;
        if (is_br) begin
          // Z holds PC+offset; loading it into PC is gated by the branch
          // condition. Not taken leaves the fetch-incremented PC in place.
          Zlowout = 1'b1;
          PCin    = CON;
        end else if (is_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end else if (is_st) begin
          // MDR loads from the bus (Read low) so Ra's value is stored.
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end
      end
      T7: begin
        Run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: begin
        // S_RST, S_HALT and unreachable codes: everything low, Run low.
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer

module tb_control_sequencer;

  logic        Clock;
  logic        Clear;
  logic [31:0] IR;
  logic        CON;
`ifdef CU_STOP_EN
  logic        Stop;
`endif
  logic PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, ADD, Run;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON),
`ifdef CU_STOP_EN
    .Stop(Stop),
`endif
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONIn(CONIn), .ADD(ADD),
    .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [22:0] word;
  assign word = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                 IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, ADD, Run};

  localparam logic [22:0] M_PCOUT   = 23'd1 << 22;
  localparam logic [22:0] M_ZLOWOUT = 23'd1 << 20;
  localparam logic [22:0] M_MDROUT  = 23'd1 << 19;
  localparam logic [22:0] M_MARIN   = 23'd1 << 18;
  localparam logic [22:0] M_ZIN     = 23'd1 << 17;
  localparam logic [22:0] M_PCIN    = 23'd1 << 16;
  localparam logic [22:0] M_MDRIN   = 23'd1 << 15;
  localparam logic [22:0] M_IRIN    = 23'd1 << 14;
  localparam logic [22:0] M_YIN     = 23'd1 << 13;
  localparam logic [22:0] M_INCPC   = 23'd1 << 12;
  localparam logic [22:0] M_READ    = 23'd1 << 11;
  localparam logic [22:0] M_WRITE   = 23'd1 << 10;
  localparam logic [22:0] M_GRA     = 23'd1 << 9;
  localparam logic [22:0] M_GRB     = 23'd1 << 8;
  localparam logic [22:0] M_RIN     = 23'd1 << 6;
  localparam logic [22:0] M_ROUT    = 23'd1 << 5;
  localparam logic [22:0] M_BAOUT   = 23'd1 << 4;
  localparam logic [22:0] M_COUT    = 23'd1 << 3;
  localparam logic [22:0] M_CONIN   = 23'd1 << 2;
  localparam logic [22:0] M_ADD     = 23'd1 << 1;
  localparam logic [22:0] M_RUN     = 23'd1 << 0;

  localparam logic [22:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [22:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [22:0] F2 = M_MDROUT | M_IRIN | M_RUN;

  logic [22:0] exp_w [8];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Entered at a negedge with the FSM in T0. CON is held at the inverse of
  // 'con' on every step except T6, so outputs outside T6 must not follow it.
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic con, input int n);
    IR = ir;
    for (int i = 0; i < n; i++) begin
      CON = (i == 6) ? con : ~con;
      #1;
      check($sformatf("%s_T%0d", tag, i), {9'd0, word}, {9'd0, exp_w[i]});
      @(negedge Clock);
    end
    CON = 1'b0;
    #1;
    check($sformatf("%s_ret_T0", tag), {9'd0, word}, {9'd0, F0});
  endtask

  initial begin
    Clear = 1'b1;
    IR    = 32'h0;
    CON   = 1'b0;
`ifdef CU_STOP_EN
    Stop  = 1'b0;
`endif
    // Reset: two cycles of Clear, all outputs low.
    @(negedge Clock);
    check("rst_c1", {9'd0, word}, 32'd0);
    @(negedge Clock);
    check("rst_c2", {9'd0, word}, 32'd0);
    Clear = 1'b0;
    @(negedge Clock);
    check("rst_T0", {9'd0, word}, {9'd0, F0});

    // br taken / not taken
    exp_w = '{F0, F1, F2, M_GRA | M_ROUT | M_CONIN | M_RUN, M_PCOUT | M_YIN | M_RUN,
              M_COUT | M_ADD | M_ZIN | M_RUN, M_ZLOWOUT | M_PCIN | M_RUN, 23'd0};
    run_instr("br_taken", 32'h9160_0023, 1'b1, 7);
    exp_w[6] = M_ZLOWOUT | M_RUN;
    run_instr("br_not", 32'h9160_0023, 1'b0, 7);

    // ld
    exp_w = '{F0, F1, F2, M_GRB | M_BAOUT | M_YIN | M_RUN, M_COUT | M_ADD | M_ZIN | M_RUN,
              M_ZLOWOUT | M_MARIN | M_RUN, M_READ | M_MDRIN | M_RUN,
              M_MDROUT | M_GRA | M_RIN | M_RUN};
    run_instr("ld", {5'b00000, 27'h0123_456}, 1'b0, 8);

    // st
    exp_w[6] = M_GRA | M_ROUT | M_MDRIN | M_RUN;
    exp_w[7] = M_WRITE | M_RUN;
    run_instr("st", {5'b00001, 27'h0654_321}, 1'b1, 8);

    // addi
    exp_w = '{F0, F1, F2, M_GRB | M_ROUT | M_YIN | M_RUN, M_COUT | M_ADD | M_ZIN | M_RUN,
              M_ZLOWOUT | M_GRA | M_RIN | M_RUN, 23'd0, 23'd0};
    run_instr("addi", {5'b01100, 27'h0000_00f}, 1'b0, 6);

    // jr, nop, undefined opcode
    exp_w = '{F0, F1, F2, M_GRA | M_ROUT | M_PCIN | M_RUN, 23'd0, 23'd0, 23'd0, 23'd0};
    run_instr("jr", {5'b10100, 27'h0200_000}, 1'b0, 4);
    exp_w[3] = M_RUN;
    run_instr("nop", {5'b11010, 27'h0}, 1'b0, 4);
    run_instr("undef", {5'b00111, 27'h1ab_cdef}, 1'b1, 4);

    // Clear during ld T5 aborts: next cycle all low, then T0.
    exp_w = '{F0, F1, F2, M_GRB | M_BAOUT | M_YIN | M_RUN, M_COUT | M_ADD | M_ZIN | M_RUN,
              M_ZLOWOUT | M_MARIN | M_RUN, 23'd0, 23'd0};
    IR = {5'b00000, 27'h0};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("abort_T%0d", i), {9'd0, word}, {9'd0, exp_w[i]});
      if (i < 5) @(negedge Clock);
    end
    Clear = 1'b1;
    @(negedge Clock);
    check("abort_rst", {9'd0, word}, 32'd0);
    Clear = 1'b0;
    @(negedge Clock);
    check("abort_T0", {9'd0, word}, {9'd0, F0});

    // halt: Run falls after T3, outputs stay low, Clear restarts.
    IR = {5'b11011, 27'h0};
    exp_w = '{F0, F1, F2, M_RUN, 23'd0, 23'd0, 23'd0, 23'd0};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("halt_T%0d", i), {9'd0, word}, {9'd0, exp_w[i]});
      @(negedge Clock);
    end
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt_hold%0d", i), {9'd0, word}, 32'd0);
      @(negedge Clock);
    end
    Clear = 1'b1;
    @(negedge Clock);
    check("halt_clr", {9'd0, word}, 32'd0);
    Clear = 1'b0;
    @(negedge Clock);
    check("halt_T0", {9'd0, word}, {9'd0, F0});

`ifdef CU_STOP_EN
    // Stop held high through jr: ignored in T0..T2, halts at T3 exit.
    IR   = {5'b10100, 27'h0};
    Stop = 1'b1;
    exp_w = '{F0, F1, F2, M_GRA | M_ROUT | M_PCIN | M_RUN, 23'd0, 23'd0, 23'd0, 23'd0};
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("stop_T%0d", i), {9'd0, word}, {9'd0, exp_w[i]});
      @(negedge Clock);
    end
    Stop = 1'b0;
    #1;
    check("stop_halt", {9'd0, word}, 32'd0);
    @(negedge Clock);
    check("stop_hold", {9'd0, word}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
